// File: rtl/multi_dataflow_engine_pkg.sv
// Shared types for the dataflow engine: control/flag structs toward the control FSM
// and the HLS kernel adapter, engine state encoding and sizing constants.
package multi_dataflow_package;

    localparam int CNT_LEN = 1024;
    localparam int CW      = $clog2(CNT_LEN) + 1;

    localparam logic [15:0] ENGINE_TIMEOUT_CYCLES = 16'hFFFF;

    typedef struct packed {
        logic          clear;
        logic          enable;
        logic          start;
        logic [CW-1:0] cnt_limit_outStream0;
        logic [31:0]   custom_reg0;
    } ctrl_engine_t;

    typedef struct packed {
        logic [CW-1:0] cnt_outStream0;
        logic          done;
        logic          ready;
    } flags_engine_t;

    typedef struct packed {
        logic ap_start;
    } ctrl_kernel_adapter_t;

    typedef struct packed {
        logic ap_done;
        logic ap_idle;
        logic ap_ready;
    } flags_kernel_adapter_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } engine_state_t;

endpackage

// File: rtl/multi_dataflow_engine_out_buffer.sv
// Small registered FIFO holding kernel output beats until the outStream0 sink takes them.
module multi_dataflow_out_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == FULL_CNT);
    assign do_pop_s  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer can still accept a push.
    assign do_push_s = push & (~full | do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage array, written at the tail pointer
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/multi_dataflow_engine.sv
// Engine responder: sequences the kernel ap_ctrl_hs handshake, gates inStream0 into the
// kernel and buffers/counts outStream0 beats. Watchdog via MULTI_DATAFLOW_ENGINE_TIMEOUT_EN.
module multi_dataflow_engine
    import multi_dataflow_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ctrl_engine_t          ctrl_i,
    output flags_engine_t         flags_o,
    output ctrl_kernel_adapter_t  kernel_ctrl_o,
    input  flags_kernel_adapter_t kernel_flags_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] k_in_data_o,
    output logic                  k_in_valid_o,
    input  logic                  k_in_ready_i,
    input  logic [DATA_WIDTH-1:0] k_out_data_i,
    input  logic                  k_out_valid_i,
    output logic                  k_out_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  timeout_o
);

    engine_state_t state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic [CW-1:0] limit_s;
    logic          kdone_r;
    logic          ap_start_r;
    logic          done_r;
    logic          ready_r;
    logic          run_s;
    logic          hs_s;
    logic          push_s;
    logic          start_ok_s;
    logic          flush_s;
    logic          finish_s;
    logic          wd_trip_s;
    logic          buf_full_s;
    logic          buf_empty_s;
    logic          unused_s;

    assign limit_s    = ctrl_i.cnt_limit_outStream0;
    assign run_s      = (state_r == RUN) & ctrl_i.enable;
    assign start_ok_s = (state_r == IDLE) & ctrl_i.start & ctrl_i.enable & ~ctrl_i.clear;
    assign flush_s    = ctrl_i.clear | start_ok_s;

    assign k_in_data_o  = in_data_i;
    assign k_in_valid_o = in_valid_i & run_s;
    assign in_ready_o   = k_in_ready_i & run_s;

    assign k_out_ready_o = ~buf_full_s & run_s;
    assign push_s        = k_out_valid_i & k_out_ready_o;
    assign out_valid_o   = ~buf_empty_s & run_s & (cnt_r < limit_s);
    assign hs_s          = out_valid_o & out_ready_i;
    assign cnt_next_s    = hs_s ? (cnt_r + CW'(1)) : cnt_r;
    assign finish_s      = (cnt_next_s == limit_s) & (kdone_r | kernel_flags_i.ap_done);

    assign flags_o.cnt_outStream0 = cnt_r;
    assign flags_o.done           = done_r;
    assign flags_o.ready          = ready_r;
    assign kernel_ctrl_o.ap_start = ap_start_r;

    assign unused_s = ^{ctrl_i.custom_reg0, kernel_flags_i.ap_idle};

    multi_dataflow_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_out_buffer (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (flush_s),
        .push      (push_s),
        .push_data (k_out_data_i),
        .pop       (hs_s),
        .pop_data  (out_data_o),
        .full      (buf_full_s),
        .empty     (buf_empty_s)
    );

`ifdef MULTI_DATAFLOW_ENGINE_TIMEOUT_EN
    logic [15:0] wd_r;
    logic        timeout_r;

    // A regular finish in the same cycle takes precedence over the watchdog.
    assign wd_trip_s = run_s & ~hs_s & ~finish_s & (wd_r == (ENGINE_TIMEOUT_CYCLES - 16'd1));
    assign timeout_o = timeout_r;

    // Watchdog: counts enabled RUN cycles without an outStream0 handshake
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_s) begin
            wd_r      <= 16'd0;
            timeout_r <= 1'b0;
        end else if (run_s) begin
            wd_r <= hs_s ? 16'd0 : (wd_r + 16'd1);
            if (wd_trip_s) begin
                timeout_r <= 1'b1;
            end
        end else begin
            wd_r <= wd_r;
        end
    end
`else
    assign wd_trip_s = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Control FSM: start/stop sequencing, beat counting and registered status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            kdone_r    <= 1'b0;
            ap_start_r <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        cnt_r   <= '0;
                        kdone_r <= 1'b0;
                        ready_r <= 1'b0;
                        if (limit_s == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r    <= START;
                            ap_start_r <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (kernel_flags_i.ap_done) begin
                        kdone_r <= 1'b1;
                    end
                    if (ctrl_i.enable && kernel_flags_i.ap_ready) begin
                        state_r    <= RUN;
                        ap_start_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (kernel_flags_i.ap_done) begin
                        kdone_r <= 1'b1;
                    end
                    if (ctrl_i.enable) begin
                        cnt_r <= cnt_next_s;
                        if (finish_s || wd_trip_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    ap_start_r <= 1'b0;
                    ready_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule
